// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper controller: CMD word layout, default
// period limits, channel FSM states and the half-step coil decode.
package stepper_pkg;

   // CMD word bit positions (the period field occupies [CNT_W-1:0])
   localparam int CMD_EN_A    = 22;
   localparam int CMD_EN_B    = 23;
   localparam int CMD_DIR     = 24;
   localparam int CMD_HALF    = 25;
   localparam int CMD_COUNTED = 26;

   // Default legal step-period range, in clocks
   localparam int DEF_MIN_PERIOD = 263158;
   localparam int DEF_MAX_PERIOD = 1000000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONT,
      ST_MOVE,
      ST_DONE
   } ch_state_t;

   // Decode a half-step index into {coilA_on, coilB_on, p1, p2}.
   // Full steps S0..S3 are (p1,p2) = 00, 01, 11, 10, so p1 = h[2] and
   // p2 = h[2]^h[1]. Odd h sits between S(k) and S(k+1): the phases keep
   // the S(k) values and the coil that changes on that transition is off
   // (coil B between S0/S1 and S2/S3, coil A between S1/S2 and S3/S0).
   function automatic logic [3:0] half_step_drive(input logic [2:0] h);
      logic p1;
      logic p2;
      logic a_on;
      logic b_on;
      p1   = h[2];
      p2   = h[2] ^ h[1];
      a_on = !(h[0] && h[1]);
      b_on = !(h[0] && !h[1]);
      return {a_on, b_on, p1, p2};
   endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: CMD/STEPS storage, step-period counter, half-step
// sequencer and the CONT/MOVE/DONE/IDLE control FSM.
module stepper_channel
   import stepper_pkg::*;
#(
   parameter int CNT_W      = 22,
   parameter int MIN_PERIOD = DEF_MIN_PERIOD,
   parameter int MAX_PERIOD = DEF_MAX_PERIOD
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic [31:0] data_in,
   input  logic        wr_cmd,
   input  logic        wr_steps,
   output logic [31:0] cmd,
   output logic [15:0] steps_remaining,
   output logic        busy,
   output logic        done,
   output logic [5:0]  ja
);

   ch_state_t        state;
   ch_state_t        state_nxt;
   logic [15:0]      steps_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] limit_p1;
   logic [2:0]       h;
   logic [2:0]       h_step;
   logic [2:0]       h_nxt;
   logic             running;
   logic             step_evt;
   logic             load_ok;
   logic [3:0]       drive;

   // Saturate a requested period into the legal range
   function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] period);
      logic [CNT_W-1:0] lo;
      logic [CNT_W-1:0] hi;
      lo = CNT_W'(MIN_PERIOD);
      hi = CNT_W'(MAX_PERIOD);
      if (period < lo) return lo;
      if (period > hi) return hi;
      return period;
   endfunction

   assign running  = (state == ST_CONT) || (state == ST_MOVE);
   // ">=" rather than "==" so a limit shrinking below the count fires at once
   assign step_evt = running && (cnt >= limit_p1);
   assign load_ok  = wr_steps && cmd[CMD_COUNTED];

   // CMD register holds the last word written to this channel
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) cmd <= '0;
      else if (wr_cmd) cmd <= data_in;
   end

   // Stage p1: clamped limit, one cycle behind the CMD register
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) limit_p1 <= CNT_W'(MIN_PERIOD);
      else             limit_p1 <= clamp_period(cmd[CNT_W-1:0]);
   end

   // Step-period counter: runs only while stepping, restarts on each event
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN)                cnt <= '0;
      else if (!running || step_evt) cnt <= '0;
      else                           cnt <= cnt + CNT_W'(1);
   end

   // Next half-step index: advance on events, round to a full step on a
   // half-to-full switch in the direction of travel
   always_comb begin
      h_step = h;
      if (step_evt) begin
         if (cmd[CMD_HALF]) h_step = cmd[CMD_DIR] ? h - 3'd1 : h + 3'd1;
         else               h_step = cmd[CMD_DIR] ? h - 3'd2 : h + 3'd2;
      end
      h_nxt = h_step;
      if (wr_cmd && !data_in[CMD_HALF] && h_step[0])
         h_nxt = data_in[CMD_DIR] ? h_step - 3'd1 : h_step + 3'd1;
   end

   // Sequencer position register
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) h <= 3'd0;
      else             h <= h_nxt;
   end

   // FSM state and remaining-step register
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state           <= ST_IDLE;
         steps_remaining <= 16'd0;
      end else begin
         state           <= state_nxt;
         steps_remaining <= steps_nxt;
      end
   end

   // FSM next state; a STEPS load always beats a coincident step event
   always_comb begin
      state_nxt = state;
      steps_nxt = steps_remaining;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (state == ST_DONE) state_nxt = ST_IDLE;
            if (wr_cmd && !data_in[CMD_COUNTED]) begin
               state_nxt = ST_CONT;
            end else if (load_ok) begin
               steps_nxt = data_in[15:0];
               state_nxt = (data_in[15:0] != 16'd0) ? ST_MOVE : ST_DONE;
            end
         end
         ST_CONT: begin
            if (load_ok) begin
               steps_nxt = data_in[15:0];
               state_nxt = (data_in[15:0] != 16'd0) ? ST_MOVE : ST_DONE;
            end
         end
         ST_MOVE: begin
            if (wr_cmd && !data_in[CMD_COUNTED]) begin
               state_nxt = ST_CONT;
            end else if (load_ok) begin
               steps_nxt = data_in[15:0];
               state_nxt = (data_in[15:0] != 16'd0) ? ST_MOVE : ST_DONE;
            end else if (step_evt) begin
               if (steps_remaining <= 16'd1) begin
                  steps_nxt = 16'd0;
                  state_nxt = ST_DONE;
               end else begin
                  steps_nxt = steps_remaining - 16'd1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy  = (state == ST_MOVE);
   assign done  = (state == ST_DONE);
   assign drive = half_step_drive(h);
   assign ja    = {cmd[CMD_EN_A] & drive[3], cmd[CMD_EN_B] & drive[2],
                   drive[1], ~drive[1], drive[0], ~drive[0]};

endmodule

// File: rtl/stepper_ctrl.sv
// Multi-channel stepper controller: decodes register writes to channels and
// muxes the selected channel's register back onto data_out.
module stepper_ctrl
   import stepper_pkg::*;
#(
   parameter  int NUM_CH     = 2,
   parameter  int CNT_W      = 22,
   parameter  int MIN_PERIOD = DEF_MIN_PERIOD,
   parameter  int MAX_PERIOD = DEF_MAX_PERIOD,
   localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                CLK100MHZ,
   input  logic                CPU_RESETN,
   input  logic [31:0]         data_in,
   input  logic                new_data,
   input  logic [SEL_W-1:0]    ch_sel,
   input  logic                addr,
   output logic [31:0]         data_out,
   output logic [NUM_CH-1:0]   busy,
   output logic [NUM_CH-1:0]   done,
   output logic [6*NUM_CH-1:0] JA
);

   logic [31:0] cmd_w   [NUM_CH];
   logic [15:0] steps_w [NUM_CH];

   // A ch_sel beyond the last channel matches no instance, so the write is dropped
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic sel;
      assign sel = new_data && (ch_sel == SEL_W'(c));

      stepper_channel #(
         .CNT_W      (CNT_W),
         .MIN_PERIOD (MIN_PERIOD),
         .MAX_PERIOD (MAX_PERIOD)
      ) u_ch (
         .CLK100MHZ       (CLK100MHZ),
         .CPU_RESETN      (CPU_RESETN),
         .data_in         (data_in),
         .wr_cmd          (sel && !addr),
         .wr_steps        (sel && addr),
         .cmd             (cmd_w[c]),
         .steps_remaining (steps_w[c]),
         .busy            (busy[c]),
         .done            (done[c]),
         .ja              (JA[6*c +: 6])
      );
   end

   // Readback mux; an out-of-range channel reads as zero
   always_comb begin
      data_out = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (ch_sel == SEL_W'(c)) data_out = addr ? {16'b0, steps_w[c]} : cmd_w[c];
      end
   end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Bench for stepper_ctrl: readback vector table, hand-built corner sequences
// and a randomized run against a behavioural channel model.
module tb_stepper_ctrl;

   localparam int NCH    = 3;
   localparam int TB_MIN = 10;
   localparam int TB_MAX = 60;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] data_in = '0;
   logic        new_data = 1'b0;
   logic [1:0]  ch_sel = '0;
   logic        addr = 1'b0;
   logic [31:0] data_out;
   logic [2:0]  busy;
   logic [2:0]  done;
   logic [17:0] JA;

   int vectors = 0;
   int miscompares = 0;

   stepper_ctrl #(
      .NUM_CH     (NCH),
      .CNT_W      (22),
      .MIN_PERIOD (TB_MIN),
      .MAX_PERIOD (TB_MAX)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rstn),
      .data_in    (data_in),
      .new_data   (new_data),
      .ch_sel     (ch_sel),
      .addr       (addr),
      .data_out   (data_out),
      .busy       (busy),
      .done       (done),
      .JA         (JA)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 continuous, 2 counted move, 3 done pulse
   logic [31:0] m_cmd   [NCH];
   int          m_mode  [NCH];
   int          m_cnt   [NCH];
   int          m_lim   [NCH];
   int          m_pos   [NCH];
   int          m_steps [NCH];

   function automatic int mclamp(input int p);
      if (p < TB_MIN) return TB_MIN;
      if (p > TB_MAX) return TB_MAX;
      return p;
   endfunction

   // Coil pattern from the full-step table and the half-step rule
   function automatic logic [5:0] model_ja(input int pos, input logic [31:0] cmd);
      logic [7:0] tbl;
      logic [1:0] a;
      logic [1:0] b;
      logic       aon;
      logic       bon;
      int         k;
      tbl = 8'b10_11_01_00;
      k   = pos / 2;
      a   = tbl[2*k +: 2];
      b   = tbl[2*((k+1)%4) +: 2];
      aon = 1'b1;
      bon = 1'b1;
      if (pos % 2 == 1) begin
         aon = (a[1] == b[1]);
         bon = (a[0] == b[0]);
      end
      return {cmd[22] & aon, cmd[23] & bon, a[1], ~a[1], a[0], ~a[0]};
   endfunction

   function automatic logic [17:0] model_ja_all();
      logic [17:0] r;
      for (int c = 0; c < NCH; c++) r[6*c +: 6] = model_ja(m_pos[c], m_cmd[c]);
      return r;
   endfunction

   function automatic logic [2:0] model_flag(input int mode);
      logic [2:0] r;
      for (int c = 0; c < NCH; c++) r[c] = (m_mode[c] == mode);
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input int ch, input logic a);
      if (ch >= NCH) return 32'd0;
      return a ? {16'd0, 16'(m_steps[ch])} : m_cmd[ch];
   endfunction

   always @(posedge clk) begin
      bit run, ev, wc, ws, ld;
      int np, nm, ns;
      if (!rstn) begin
         for (int c = 0; c < NCH; c++) begin
            m_cmd[c] = '0; m_mode[c] = 0; m_cnt[c] = 0;
            m_lim[c] = TB_MIN; m_pos[c] = 0; m_steps[c] = 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            run = (m_mode[c] == 1) || (m_mode[c] == 2);
            ev  = run && (m_cnt[c] >= m_lim[c]);
            wc  = new_data && (int'(ch_sel) == c) && !addr;
            ws  = new_data && (int'(ch_sel) == c) && addr;
            ld  = ws && m_cmd[c][26];
            np  = m_pos[c];
            if (ev) np = (np + 8 + (m_cmd[c][25] ? 1 : 2) * (m_cmd[c][24] ? -1 : 1)) % 8;
            if (wc && !data_in[25] && (np % 2 == 1)) np = (np + (data_in[24] ? 7 : 1)) % 8;
            nm = m_mode[c];
            ns = m_steps[c];
            if (m_mode[c] == 2 && wc && !data_in[26]) begin
               nm = 1;
            end else if ((m_mode[c] == 0 || m_mode[c] == 3) && wc && !data_in[26]) begin
               nm = 1;
            end else if (ld) begin
               ns = int'(data_in[15:0]);
               nm = (ns != 0) ? 2 : 3;
            end else if (m_mode[c] == 2 && ev) begin
               ns = ns - 1;
               if (ns == 0) nm = 3;
            end else if (m_mode[c] == 3) begin
               nm = 0;
            end
            m_cnt[c] = (!run || ev) ? 0 : m_cnt[c] + 1;
            m_lim[c] = mclamp(int'(m_cmd[c][21:0]));
            if (wc) m_cmd[c] = data_in;
            m_pos[c] = np; m_mode[c] = nm; m_steps[c] = ns;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      new_data = 1'b0;
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic wr(input int ch, input logic a, input logic [31:0] d);
      ch_sel = 2'(ch);
      addr = a;
      data_in = d;
      new_data = 1'b1;
      tick();
      new_data = 1'b0;
   endtask

   // Ticks until channel ch's JA slice changes; n = -1 if the bound expires
   task automatic wait_change(input int ch, input int bound, output int n);
      logic [5:0] st;
      st = JA[6*ch +: 6];
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         tick();
         if (JA[6*ch +: 6] !== st) begin
            n = i;
            break;
         end
      end
   endtask

   typedef struct {
      int          ch;
      logic        a;
      logic        w;
      logic [31:0] d;
      logic [31:0] exp;
   } rb_vec_t;

   rb_vec_t tbl [12];

   initial begin
      int n;
      int cnt_chg;
      int pulses;
      logic prev_busy;
      logic [5:0] prev_ja;
      logic [31:0] d;

      tbl[0]  = '{0, 1'b0, 1'b1, 32'hFC00_0123, 32'hFC00_0123};
      tbl[1]  = '{1, 1'b0, 1'b1, 32'h0A80_0FFF, 32'h0A80_0FFF};
      tbl[2]  = '{2, 1'b0, 1'b1, 32'h04C0_0040, 32'h04C0_0040};
      tbl[3]  = '{3, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
      tbl[4]  = '{0, 1'b0, 1'b0, 32'h0,         32'hFC00_0123};
      tbl[5]  = '{1, 1'b0, 1'b0, 32'h0,         32'h0A80_0FFF};
      tbl[6]  = '{3, 1'b1, 1'b1, 32'h0000_0005, 32'h0000_0000};
      tbl[7]  = '{0, 1'b1, 1'b0, 32'h0,         32'h0000_0000};
      tbl[8]  = '{0, 1'b1, 1'b1, 32'hABCD_0000, 32'h0000_0000};
      tbl[9]  = '{2, 1'b1, 1'b1, 32'h1234_0007, 32'h0000_0007};
      tbl[10] = '{2, 1'b0, 1'b0, 32'h0,         32'h04C0_0040};
      tbl[11] = '{1, 1'b1, 1'b0, 32'h0,         32'h0000_0000};

      // Reset state
      do_reset();
      check("reset_ja", 32'(JA), 32'(18'b000101_000101_000101));
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);

      // Register readback table
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].w) wr(tbl[i].ch, tbl[i].a, tbl[i].d);
         ch_sel = 2'(tbl[i].ch);
         addr = tbl[i].a;
         #1;
         check($sformatf("readback[%0d]", i), data_out, tbl[i].exp);
      end

      // Clamped period: limit 10 gives 11-clock step interval
      do_reset();
      wr(0, 1'b0, 32'h00C0_0003);
      check("clamp_ja_s0", 32'(JA[5:0]), 32'(6'b110101));
      wait_change(0, 40, n);
      check("clamp_first_step", n, 11);
      check("clamp_ja_s1", 32'(JA[5:0]), 32'(6'b110110));
      wait_change(0, 40, n);
      check("clamp_interval", n, 11);
      check("clamp_ja_s2", 32'(JA[5:0]), 32'(6'b111010));

      // Counted move of 5 full steps forward
      do_reset();
      wr(0, 1'b0, 32'h04C0_000A);
      wr(0, 1'b1, 32'h0000_0005);
      check("move_busy", 32'(busy[0]), 32'd1);
      pulses = 0;
      prev_busy = busy[0];
      n = -1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (done[0]) begin
            pulses++;
            n = i;
            check("move_busy_prev", 32'(prev_busy), 32'd1);
            check("move_busy_at_done", 32'(busy[0]), 32'd0);
            check("move_end_ja", 32'(JA[5:0]), 32'(6'b110110));
            break;
         end
         prev_busy = busy[0];
      end
      check("move_done_seen", 32'(n >= 0), 32'd1);
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done[0]) pulses++;
      end
      check("move_done_pulses", pulses, 1);
      check("move_end_ja_hold", 32'(JA[5:0]), 32'(6'b110110));

      // Half-step reverse from h=0
      do_reset();
      wr(0, 1'b0, 32'h03C0_000A);
      wait_change(0, 40, n);
      check("half_rev_step1", n, 11);
      check("half_rev_h7_ja", 32'(JA[5:0]), 32'(6'b011001));
      wait_change(0, 40, n);
      check("half_rev_h6_ja", 32'(JA[5:0]), 32'(6'b111001));

      // Period shrink below the running count
      do_reset();
      wr(0, 1'b0, 32'h00C0_003C);
      for (int i = 0; i < 50; i++) tick();
      wr(0, 1'b0, 32'h00C0_0014);
      check("shrink_no_early_step", 32'(JA[5:0]), 32'(6'b110101));
      wait_change(0, 10, n);
      check("shrink_immediate_step", n, 2);
      wait_change(0, 60, n);
      check("shrink_new_interval", n, 21);

      // STEPS write on the same cycle as a step event
      do_reset();
      wr(0, 1'b0, 32'h00C0_000A);
      wr(0, 1'b0, 32'h04C0_000A);
      wait_change(0, 40, n);
      check("sim_sync", n, 10);
      for (int i = 0; i < 10; i++) tick();
      wr(0, 1'b1, 32'h0000_0003);
      addr = 1'b1;
      ch_sel = 2'd0;
      #1;
      check("sim_steps_loaded", data_out, 32'd3);
      check("sim_coincident_step", 32'(JA[5:0]), 32'(6'b111010));
      check("sim_busy", 32'(busy[0]), 32'd1);
      cnt_chg = 0;
      prev_ja = JA[5:0];
      n = -1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (JA[5:0] !== prev_ja) cnt_chg++;
         prev_ja = JA[5:0];
         if (done[0]) begin
            n = i;
            break;
         end
      end
      check("sim_done_seen", 32'(n >= 0), 32'd1);
      check("sim_further_steps", cnt_chg, 3);
      check("sim_end_ja", 32'(JA[5:0]), 32'(6'b110110));

      // Reset in the middle of a move
      do_reset();
      wr(0, 1'b0, 32'h04C0_000A);
      wr(0, 1'b1, 32'h0000_0064);
      for (int i = 0; i < 30; i++) tick();
      check("midrst_busy_before", 32'(busy[0]), 32'd1);
      rstn = 1'b0;
      tick();
      pulses = (done != 3'b000) ? 1 : 0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ja", 32'(JA), 32'(18'b000101_000101_000101));
      rstn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (done != 3'b000) pulses++;
      end
      check("midrst_no_done", pulses, 0);

      // Writes to a channel that does not exist
      do_reset();
      wr(3, 1'b0, 32'h00C0_000A);
      wr(3, 1'b1, 32'h0000_0005);
      for (int i = 0; i < 30; i++) tick();
      check("range_ja", 32'(JA), 32'(18'b000101_000101_000101));
      check("range_busy", 32'(busy), 32'd0);
      for (int c = 0; c < NCH; c++) begin
         ch_sel = 2'(c);
         addr = 1'b0;
         #1;
         check($sformatf("range_cmd%0d", c), data_out, 32'd0);
      end

      // Randomized traffic against the model
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         new_data = 1'b0;
         ch_sel = 2'($urandom_range(0, 3));
         addr = 1'($urandom_range(0, 1));
         rstn = ($urandom_range(0, 599) != 0);
         if ($urandom_range(0, 4) == 0) begin
            d = $urandom;
            if (!addr) begin
               d[21:0] = 22'($urandom_range(0, 70));
               d[26] = 1'($urandom_range(0, 1));
            end else begin
               d[15:0] = 16'($urandom_range(0, 6));
            end
            data_in = d;
            new_data = 1'b1;
         end
         #1;
         check("rand_ja", 32'(JA), 32'(model_ja_all()));
         check("rand_busy", 32'(busy), 32'(model_flag(2)));
         check("rand_done", 32'(done), 32'(model_flag(3)));
         check("rand_readback", data_out, model_rd(int'(ch_sel), addr));
         tick();
      end
      new_data = 1'b0;
      rstn = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
